// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: CSR addresses,
// Zicsr funct3 encodings, interrupt cause codes and redirect FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM_LO       = 12'hB03;
  localparam logic [11:0] CSR_MHPM_LAST     = 12'hB1F;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMH_LO      = 12'hB83;
  localparam logic [11:0] CSR_MHPMH_LAST    = 12'hB9F;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } csr_funct3_e;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } csr_state_e;

  // mcycle (0) and minstret (2) are always inhibitable; bit 1 stays hardwired low.
  function automatic logic [31:0] inhibit_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < 29; i++) begin
      if (i < num_hpm) m[3+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running event counter with separately writable low/high 32-bit halves.
// A CSR write in the same cycle as an increment takes precedence.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0] <= wdata;
      if (wr_hi) cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (inc && !inhibit) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file, interrupt arbitration and valid/ready PC redirect to IF.
// Optional hardware performance counters are built when CSR_HPM_EN is defined.
//
// state | meaning
// RUN   | normal execution, traps and mret accepted
// REDIR | redirect presented to IF, held until redir_ready
module csr_mtrap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_HPM   = 4,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid,
  input  logic [2:0]         csr_funct3,
  input  logic [11:0]        csr_addr,
  input  logic [4:0]         csr_rs1_idx,
  input  logic [4:0]         csr_rd_idx,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               mret_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_pc_valid,
  input  logic               retire,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               irq_ext,
  input  logic               irq_tmr,
  input  logic               irq_sw,
  output logic               redir_valid,
  output logic [31:0]        redir_pc,
  input  logic               redir_ready
);

`ifdef CSR_HPM_EN
  localparam int HPM_IMPL = NUM_HPM;
`else
  localparam int HPM_IMPL = 0;
`endif
  localparam logic [31:0] INH_MASK = inhibit_mask(HPM_IMPL);

  csr_state_e state, state_nxt;

  logic             mst_mie, mst_mpie;
  logic [31:0]      mie_q, mtvec_q, mepc_q, mcause_q, mscratch_q, mcountinhibit_q;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  logic [31:0] mip, mstatus_rd, pend, hpm_rd;
  logic [31:0] rd_val, wr_src, wr_val;
  logic        addr_ok, addr_ro, wr_req, wr_en;
  logic        take_trap, take_mret;
  logic [4:0]  irq_code;
  logic [31:0] trap_base, trap_pc;

  logic unused_ok;
  assign unused_ok = ^{csr_rd_idx, ex_pc[1:0]};

  assign mip        = {20'b0, irq_ext, 3'b0, irq_tmr, 3'b0, irq_sw, 3'b0};
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

  // ---------------- performance counters ----------------
`ifdef CSR_HPM_EN
  logic [CNT_W-1:0] hpm_cnt [NUM_HPM];

  for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
    csr_counter #(.CNT_W(CNT_W)) u_hpm (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (hpm_event[i]),
      .inhibit (mcountinhibit_q[3+i]),
      .wr_lo   (wr_en && (csr_addr == CSR_MHPM_LO + 12'(i))),
      .wr_hi   (wr_en && (csr_addr == CSR_MHPMH_LO + 12'(i))),
      .wdata   (wr_val),
      .cnt     (hpm_cnt[i])
    );
  end

  always_comb begin
    hpm_rd = '0;
    for (int i = 0; i < NUM_HPM; i++) begin
      if (csr_addr == CSR_MHPM_LO + 12'(i))  hpm_rd = hpm_cnt[i][31:0];
      if (csr_addr == CSR_MHPMH_LO + 12'(i)) hpm_rd = 32'(hpm_cnt[i][CNT_W-1:32]);
    end
  end
`else
  logic unused_hpm;
  assign unused_hpm = ^hpm_event;
  assign hpm_rd     = '0;
`endif

  csr_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .inhibit (mcountinhibit_q[0]),
    .wr_lo   (wr_en && (csr_addr == CSR_MCYCLE)),
    .wr_hi   (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata   (wr_val),
    .cnt     (cycle_cnt)
  );

  csr_counter #(.CNT_W(CNT_W)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (retire),
    .inhibit (mcountinhibit_q[2]),
    .wr_lo   (wr_en && (csr_addr == CSR_MINSTRET)),
    .wr_hi   (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata   (wr_val),
    .cnt     (instret_cnt)
  );

  // ---------------- read decode ----------------
  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:       rd_val = mstatus_rd;
      CSR_MIE:           rd_val = mie_q;
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_val = mcountinhibit_q;
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MIP: begin
        rd_val  = mip;
        addr_ro = 1'b1;
      end
      CSR_MCYCLE:        rd_val = cycle_cnt[31:0];
      CSR_MCYCLEH:       rd_val = 32'(cycle_cnt[CNT_W-1:32]);
      CSR_MINSTRET:      rd_val = instret_cnt[31:0];
      CSR_MINSTRETH:     rd_val = 32'(instret_cnt[CNT_W-1:32]);
      default: begin
        // The whole hpm window decodes legally even when the counters are not built.
        if ((csr_addr >= CSR_MHPM_LO && csr_addr <= CSR_MHPM_LAST) ||
            (csr_addr >= CSR_MHPMH_LO && csr_addr <= CSR_MHPMH_LAST))
          rd_val = hpm_rd;
        else
          addr_ok = 1'b0;
      end
    endcase
  end

  assign csr_rdata = rd_val;
  assign wr_src    = csr_funct3[2] ? {27'b0, csr_rs1_idx} : csr_wdata;

  always_comb begin
    wr_val = rd_val;
    wr_req = 1'b0;
    case (csr_funct3)
      F3_RW, F3_RWI: begin
        wr_val = wr_src;
        wr_req = csr_valid;
      end
      F3_RS, F3_RSI: begin
        wr_val = rd_val | wr_src;
        wr_req = csr_valid && (csr_rs1_idx != 5'd0);
      end
      F3_RC, F3_RCI: begin
        wr_val = rd_val & ~wr_src;
        wr_req = csr_valid && (csr_rs1_idx != 5'd0);
      end
      default: ;
    endcase
  end

  assign csr_illegal = csr_valid && (!addr_ok || (wr_req && addr_ro));
  assign wr_en       = wr_req && !csr_illegal;

  // ---------------- interrupt arbitration ----------------
  assign pend = mip & mie_q & {32{mst_mie}};

  always_comb begin
    if (pend[11])     irq_code = CAUSE_MEI;
    else if (pend[3]) irq_code = CAUSE_MSI;
    else              irq_code = CAUSE_MTI;
  end

  assign trap_base = {mtvec_q[31:2], 2'b00};
  assign trap_pc   = (mtvec_q[1:0] == 2'b01) ? trap_base + {25'b0, irq_code, 2'b00} : trap_base;

  // ---------------- redirect FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (take_trap || take_mret) state_nxt = REDIR;
      REDIR:   if (redir_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // A CSR op in EX holds off the interrupt so the op is not half-committed.
  always_comb begin
    take_trap   = 1'b0;
    take_mret   = 1'b0;
    redir_valid = 1'b0;
    case (state)
      RUN: begin
        take_trap = (|pend) && ex_pc_valid && !csr_valid;
        take_mret = mret_valid && !take_trap;
      end
      REDIR:   redir_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- architectural registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_pc        <= '0;
      mst_mie         <= 1'b0;
      mst_mpie        <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= MTVEC_RST;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mscratch_q      <= '0;
      mcountinhibit_q <= '0;
    end else begin
      if (take_trap)      redir_pc <= trap_pc;
      else if (take_mret) redir_pc <= mepc_q;

      if (take_trap) begin
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (take_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_en && csr_addr == CSR_MSTATUS) begin
        mst_mie  <= wr_val[3];
        mst_mpie <= wr_val[7];
      end

      if (take_trap) begin
        mepc_q   <= {ex_pc[31:2], 2'b00};
        mcause_q <= {1'b1, 26'b0, irq_code};
      end else begin
        if (wr_en && csr_addr == CSR_MEPC)   mepc_q   <= {wr_val[31:2], 2'b00};
        if (wr_en && csr_addr == CSR_MCAUSE) mcause_q <= wr_val;
      end

      if (wr_en && csr_addr == CSR_MIE)           mie_q           <= wr_val & MIE_MASK;
      if (wr_en && csr_addr == CSR_MTVEC)         mtvec_q         <= wr_val;
      if (wr_en && csr_addr == CSR_MSCRATCH)      mscratch_q      <= wr_val;
      if (wr_en && csr_addr == CSR_MCOUNTINHIBIT) mcountinhibit_q <= wr_val & INH_MASK;
    end
  end

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Directed bench for csr_mtrap_unit: CSR ops, counters, trap/mret redirects, reset.
module tb_csr_mtrap_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_valid = 1'b0;
  logic [2:0]  csr_funct3 = 3'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [4:0]  csr_rs1_idx = 5'd0;
  logic [4:0]  csr_rd_idx = 5'd0;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        mret_valid = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_pc_valid = 1'b0;
  logic        retire = 1'b0;
  logic [3:0]  hpm_event = 4'h0;
  logic        irq_ext = 1'b0, irq_tmr = 1'b0, irq_sw = 1'b0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef CSR_HPM_EN
  localparam logic [31:0] EXP_INH = 32'h0000_007D;
  localparam logic [31:0] EXP_HPM = 32'h0000_0077;
`else
  localparam logic [31:0] EXP_INH = 32'h0000_0005;
  localparam logic [31:0] EXP_HPM = 32'h0000_0000;
`endif

  csr_mtrap_unit dut (
    .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_funct3(csr_funct3),
    .csr_addr(csr_addr), .csr_rs1_idx(csr_rs1_idx), .csr_rd_idx(csr_rd_idx),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .mret_valid(mret_valid), .ex_pc(ex_pc), .ex_pc_valid(ex_pc_valid), .retire(retire),
    .hpm_event(hpm_event), .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One CSR instruction in EX for one cycle; returns just after the committing edge.
  task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [31:0] wd, output logic [31:0] rd, output logic ill);
    csr_valid = 1'b1; csr_funct3 = f3; csr_addr = addr; csr_rs1_idx = rs1;
    csr_rd_idx = 5'd1; csr_wdata = wd;
    #1;
    rd = csr_rdata; ill = csr_illegal;
    @(posedge clk); #1;
    csr_valid = 1'b0;
  endtask

  task automatic peek(input logic [11:0] addr, output logic [31:0] rd);
    csr_addr = addr;
    #1;
    rd = csr_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    vec_cnt++; if (redir_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_redir_valid: got %b exp 0", redir_valid); end
    vec_cnt++; if (redir_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_redir_pc: got %h exp 0", redir_pc); end
    peek(12'h305, v);
    vec_cnt++; if (v !== 32'h0001_0000) begin err_cnt++; $display("FAIL rst_mtvec: got %h exp 00010000", v); end
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1800) begin err_cnt++; $display("FAIL rst_mstatus: got %h exp 00001800", v); end
    peek(12'hB02, v);
    vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rst_minstret: got %h exp 0", v); end
  endtask

  task automatic test_csr_ops;
    logic [31:0] v; logic ill;
    csr_op(3'b110, 12'h300, 5'd8, 32'h0, v, ill);
    vec_cnt++; if (v !== 32'h0000_1800) begin err_cnt++; $display("FAIL csrrsi_old: got %h exp 00001800", v); end
    csr_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, v, ill);
    vec_cnt++; if (v !== 32'h0000_1808) begin err_cnt++; $display("FAIL csrrs_x0_rd: got %h exp 00001808", v); end
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1808) begin err_cnt++; $display("FAIL csrrs_x0_nowrite: got %h exp 00001808", v); end
    csr_op(3'b001, 12'h340, 5'd2, 32'hDEAD_BEEF, v, ill);
    csr_op(3'b011, 12'h340, 5'd3, 32'h0000_FFFF, v, ill);
    vec_cnt++; if (v !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL csrrc_old: got %h exp deadbeef", v); end
    peek(12'h340, v);
    vec_cnt++; if (v !== 32'hDEAD_0000) begin err_cnt++; $display("FAIL csrrc_new: got %h exp dead0000", v); end
    csr_op(3'b111, 12'h300, 5'd8, 32'h0, v, ill);
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1800) begin err_cnt++; $display("FAIL csrrci_mstatus: got %h exp 00001800", v); end
    csr_op(3'b001, 12'h341, 5'd4, 32'h0000_0123, v, ill);
    peek(12'h341, v);
    vec_cnt++; if (v !== 32'h0000_0120) begin err_cnt++; $display("FAIL mepc_align: got %h exp 00000120", v); end
    csr_op(3'b001, 12'h304, 5'd4, 32'hFFFF_FFFF, v, ill);
    peek(12'h304, v);
    vec_cnt++; if (v !== 32'h0000_0888) begin err_cnt++; $display("FAIL mie_mask: got %h exp 00000888", v); end
  endtask

  task automatic test_illegal;
    logic [31:0] v; logic ill;
    csr_op(3'b010, 12'h7C0, 5'd0, 32'h0, v, ill);
    vec_cnt++; if (ill !== 1'b1 || v !== 32'h0) begin err_cnt++; $display("FAIL unimpl_addr: got ill=%b rd=%h exp ill=1 rd=0", ill, v); end
    irq_sw = 1'b1;
    csr_op(3'b010, 12'h344, 5'd0, 32'h0, v, ill);
    vec_cnt++; if (ill !== 1'b0 || v !== 32'h8) begin err_cnt++; $display("FAIL mip_read: got ill=%b rd=%h exp ill=0 rd=8", ill, v); end
    irq_sw = 1'b0;
    csr_op(3'b001, 12'h344, 5'd5, 32'h1, v, ill);
    vec_cnt++; if (ill !== 1'b1) begin err_cnt++; $display("FAIL mip_write_illegal: got %b exp 1", ill); end
    csr_op(3'b001, 12'hB03, 5'd5, 32'h77, v, ill);
    vec_cnt++; if (ill !== 1'b0) begin err_cnt++; $display("FAIL hpm_legal: got %b exp 0", ill); end
    peek(12'hB03, v);
    vec_cnt++; if (v !== EXP_HPM) begin err_cnt++; $display("FAIL hpm_read: got %h exp %h", v, EXP_HPM); end
  endtask

  task automatic test_counters;
    logic [31:0] v; logic ill;
    retire = 1'b1; tick(3); retire = 1'b0;
    peek(12'hB02, v);
    vec_cnt++; if (v !== 32'd3) begin err_cnt++; $display("FAIL minstret_count: got %h exp 3", v); end
    csr_op(3'b001, 12'hB82, 5'd1, 32'h5, v, ill);
    peek(12'hB82, v);
    vec_cnt++; if (v !== 32'h5) begin err_cnt++; $display("FAIL minstreth_write: got %h exp 5", v); end
    peek(12'hB02, v);
    vec_cnt++; if (v !== 32'd3) begin err_cnt++; $display("FAIL minstret_lo_kept: got %h exp 3", v); end
    csr_op(3'b001, 12'hB80, 5'd1, 32'h0, v, ill);
    csr_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, v, ill);
    peek(12'hB00, v);
    vec_cnt++; if (v !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mcycle_preset: got %h exp ffffffff", v); end
    tick(1);
    peek(12'hB00, v);
    vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL mcycle_wrap_lo: got %h exp 0", v); end
    peek(12'hB80, v);
    vec_cnt++; if (v !== 32'h1) begin err_cnt++; $display("FAIL mcycle_wrap_hi: got %h exp 1", v); end
    csr_op(3'b001, 12'h320, 5'd1, 32'hFFFF_FFFF, v, ill);
    peek(12'h320, v);
    vec_cnt++; if (v !== EXP_INH) begin err_cnt++; $display("FAIL inhibit_mask: got %h exp %h", v, EXP_INH); end
    csr_op(3'b001, 12'hB00, 5'd1, 32'd100, v, ill);
    tick(3);
    peek(12'hB00, v);
    vec_cnt++; if (v !== 32'd100) begin err_cnt++; $display("FAIL mcycle_frozen: got %h exp 64", v); end
    csr_op(3'b001, 12'h320, 5'd0, 32'h0, v, ill);
    tick(1);
    peek(12'hB00, v);
    vec_cnt++; if (v !== 32'd101) begin err_cnt++; $display("FAIL mcycle_resume: got %h exp 65", v); end
    csr_op(3'b001, 12'hB00, 5'd1, 32'h55, v, ill);
    peek(12'hB00, v);
    vec_cnt++; if (v !== 32'h55) begin err_cnt++; $display("FAIL mcycle_write_wins: got %h exp 55", v); end
    retire = 1'b1;
    csr_op(3'b001, 12'hB02, 5'd1, 32'h40, v, ill);
    retire = 1'b0;
    peek(12'hB02, v);
    vec_cnt++; if (v !== 32'h40) begin err_cnt++; $display("FAIL minstret_write_wins: got %h exp 40", v); end
  endtask

  task automatic test_trap_ext;
    logic [31:0] v; logic ill;
    csr_op(3'b001, 12'h304, 5'd1, 32'h800, v, ill);
    csr_op(3'b110, 12'h300, 5'd8, 32'h0, v, ill);
    irq_ext = 1'b1; ex_pc = 32'h120; ex_pc_valid = 1'b1;
    tick(1);
    ex_pc_valid = 1'b0; irq_ext = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0001_0000) begin err_cnt++; $display("FAIL ext_redirect: got v=%b pc=%h exp v=1 pc=00010000", redir_valid, redir_pc); end
    peek(12'h341, v);
    vec_cnt++; if (v !== 32'h120) begin err_cnt++; $display("FAIL ext_mepc: got %h exp 00000120", v); end
    peek(12'h342, v);
    vec_cnt++; if (v !== 32'h8000_000B) begin err_cnt++; $display("FAIL ext_mcause: got %h exp 8000000b", v); end
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1880) begin err_cnt++; $display("FAIL ext_mstatus: got %h exp 00001880", v); end
    redir_ready = 1'b1; tick(1); redir_ready = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b0) begin err_cnt++; $display("FAIL ext_release: got %b exp 0", redir_valid); end
  endtask

  task automatic test_mret;
    logic [31:0] v; logic ill;
    csr_op(3'b001, 12'h341, 5'd1, 32'h124, v, ill);
    mret_valid = 1'b1; tick(1); mret_valid = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h124) begin err_cnt++; $display("FAIL mret_redirect: got v=%b pc=%h exp v=1 pc=00000124", redir_valid, redir_pc); end
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1888) begin err_cnt++; $display("FAIL mret_mstatus: got %h exp 00001888", v); end
    redir_ready = 1'b1; tick(1); redir_ready = 1'b0;
  endtask

  task automatic test_vectored_hold;
    logic [31:0] v; logic ill;
    csr_op(3'b001, 12'h305, 5'd1, 32'h0001_0001, v, ill);
    csr_op(3'b001, 12'h304, 5'd1, 32'h80, v, ill);
    irq_tmr = 1'b1; ex_pc = 32'h200; ex_pc_valid = 1'b1;
    tick(1);
    ex_pc_valid = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0001_001C) begin err_cnt++; $display("FAIL vec_redirect: got v=%b pc=%h exp v=1 pc=0001001c", redir_valid, redir_pc); end
    mret_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0001_001C) begin err_cnt++; $display("FAIL vec_hold%0d: got v=%b pc=%h exp v=1 pc=0001001c", i, redir_valid, redir_pc); end
    end
    mret_valid = 1'b0;
    peek(12'h342, v);
    vec_cnt++; if (v !== 32'h8000_0007) begin err_cnt++; $display("FAIL vec_mcause: got %h exp 80000007", v); end
    peek(12'h300, v);
    vec_cnt++; if (v !== 32'h0000_1880) begin err_cnt++; $display("FAIL vec_mret_ignored: got %h exp 00001880", v); end
    redir_ready = 1'b1; tick(1); redir_ready = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b0) begin err_cnt++; $display("FAIL vec_release: got %b exp 0", redir_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v; logic ill;
    ex_pc = 32'h300; ex_pc_valid = 1'b1;
    csr_op(3'b110, 12'h300, 5'd8, 32'h0, v, ill);
    csr_op(3'b001, 12'h340, 5'd1, 32'h0000_ABCD, v, ill);
    vec_cnt++; if (redir_valid !== 1'b0) begin err_cnt++; $display("FAIL csr_defers_irq: got %b exp 0", redir_valid); end
    mret_valid = 1'b1;
    tick(1);
    mret_valid = 1'b0; ex_pc_valid = 1'b0; irq_tmr = 1'b0;
    vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0001_001C) begin err_cnt++; $display("FAIL irq_beats_mret: got v=%b pc=%h exp v=1 pc=0001001c", redir_valid, redir_pc); end
    peek(12'h341, v);
    vec_cnt++; if (v !== 32'h300) begin err_cnt++; $display("FAIL b2b_mepc: got %h exp 00000300", v); end
    peek(12'h340, v);
    vec_cnt++; if (v !== 32'h0000_ABCD) begin err_cnt++; $display("FAIL b2b_mscratch: got %h exp 0000abcd", v); end
    redir_ready = 1'b1; tick(1); redir_ready = 1'b0;
  endtask

  task automatic test_reset_mid_redir;
    logic [31:0] v; logic ill;
    csr_op(3'b001, 12'h304, 5'd1, 32'h8, v, ill);
    csr_op(3'b001, 12'h305, 5'd1, 32'h0000_4000, v, ill);
    irq_sw = 1'b1; ex_pc = 32'h400; ex_pc_valid = 1'b1;
    csr_op(3'b110, 12'h300, 5'd8, 32'h0, v, ill);
    tick(1);
    vec_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_4000) begin err_cnt++; $display("FAIL sw_redirect: got v=%b pc=%h exp v=1 pc=00004000", redir_valid, redir_pc); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (redir_valid !== 1'b0 || redir_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_drop_redir: got v=%b pc=%h exp v=0 pc=0", redir_valid, redir_pc); end
    peek(12'h305, v);
    vec_cnt++; if (v !== 32'h0001_0000) begin err_cnt++; $display("FAIL rst2_mtvec: got %h exp 00010000", v); end
    peek(12'hB02, v);
    vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rst2_minstret: got %h exp 0", v); end
    peek(12'hB82, v);
    vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rst2_minstreth: got %h exp 0", v); end
    tick(1);
    vec_cnt++; if (redir_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_hold: got %b exp 0", redir_valid); end
    ex_pc_valid = 1'b0; irq_sw = 1'b0;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    test_reset();
    tick(1);
    test_csr_ops();
    test_illegal();
    test_counters();
    test_trap_ext();
    test_mret();
    test_vectored_hold();
    test_back_to_back();
    test_reset_mid_redir();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
